// File: rtl/pixel_reqack_pkg.sv
// Shared types and widths for the ReqAck pixel initiator.
package pixel_reqack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam int PIX_COUNT_W = 32;
  localparam int TO_COUNT_W  = 16;

endpackage

// File: rtl/pixel_reqack_initiator_watchdog.sv
// Request watchdog: counts REQ cycles and flags the last allowed one.
module reqack_watchdog
  import pixel_reqack_pkg::*;
#(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic active_i,
  output logic expire_o
);

  localparam logic [TO_COUNT_W-1:0] LAST =
    TO_COUNT_W'(timeout_cycles - 1);

  logic [TO_COUNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the final REQ cycle the core is given.
  assign expire_o = active_i && (cnt_q == LAST);

endmodule

// File: rtl/pixel_reqack_initiator.sv
// ReqAck-mode requester between a pixel stream and a point-op core.
// Define REQACK_TIMEOUT_EN to abort requests after timeout_cycles.
module pixel_reqack_initiator
  import pixel_reqack_pkg::*;
#(
  parameter int color_channels = 3,
  parameter int color_width    = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [color_channels*color_width-1:0] in_data,
  output logic                                  in_ready,
  output logic                                  core_enable,
  output logic [color_channels*color_width-1:0] core_data,
  input  logic                                  core_ready,
  input  logic [color_channels*color_width-1:0] core_result,
  output logic                                  out_valid,
  output logic [color_channels*color_width-1:0] out_data,
  input  logic                                  out_ack,
  output logic [31:0]                           pix_count,
  output logic                                  err_timeout
);

  localparam int DW = color_channels * color_width;

  if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_to
    $error("timeout_cycles must be in 1..65535");
  end

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  logic [DW-1:0]          cd_q, cd_d;
  logic [DW-1:0]          od_q, od_d;
  logic                   ov_q, ov_d;
  logic [PIX_COUNT_W-1:0] cnt_q, cnt_d;
  logic                   accept;
  logic                   expire;

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ack);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cd_d    = cd_q;
    od_d    = od_q;
    ov_d    = ov_q && !out_ack;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cd_d    = in_data;
          en_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (core_ready) begin
          od_d    = core_result;
          ov_d    = 1'b1;
          en_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = REL;
        end else if (expire) begin
          en_d    = 1'b0;
          state_d = REL;
        end
      end
      // Hold off until the core drops its ready from the last request.
      REL: begin
        if (!core_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      cd_q    <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cd_q    <= cd_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_enable = en_q;
  assign core_data   = cd_q;
  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign pix_count   = cnt_q;

`ifdef REQACK_TIMEOUT_EN
  logic err_q;

  reqack_watchdog #(
    .timeout_cycles(timeout_cycles)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .active_i(state_q == REQ),
    .expire_o(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == REQ && !core_ready && expire) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_reqack_initiator.sv
// Randomized bench for pixel_reqack_initiator with a flag-level model.
module tb_pixel_reqack_initiator;

  localparam int CH = 3;
  localparam int CW = 8;
  localparam int DW = CH * CW;
  localparam int TO = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          core_enable;
  logic [DW-1:0] core_data;
  logic          core_ready = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ack = 1'b0;
  logic [31:0]   pix_count;
  logic          err_timeout;

  always #5 clk = ~clk;

  pixel_reqack_initiator #(
    .color_channels(CH),
    .color_width   (CW),
    .timeout_cycles(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .core_enable(core_enable),
    .core_data  (core_data),
    .core_ready (core_ready),
    .core_result(core_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ack    (out_ack),
    .pix_count  (pix_count),
    .err_timeout(err_timeout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: busy = request open, rel = waiting for core release
  bit            m_busy, m_rel, m_ov, m_err;
  logic [DW-1:0] m_od, m_cd;
  logic [31:0]   m_cnt;
  int            m_to;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] dl_q[$];
  logic [DW-1:0] feed_q[$];
  bit            last_acc;

  int mode = 0;
  bit auto_core = 1'b1;
  int lat = 0, hold = 0;
  int lat_lo = 0, lat_hi = 0, hold_lo = 0, hold_hi = 0;

  function automatic logic [DW-1:0] xform(logic [DW-1:0] p);
    logic [DW-1:0] r;
    logic [CW-1:0] c;
    r = '0;
    for (int k = 0; k < CH; k++) begin
      c = p[k*CW +: CW];
      r[k*CW +: CW] = (mode == 0) ? c + 8'd1 : (c | (c >> 1));
    end
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_rel = 0; m_ov = 0; m_err = 0;
    m_od = '0; m_cd = '0; m_cnt = '0; m_to = 0;
    sb_q.delete();
  endtask

  task automatic tick();
    bit exp_rdy, acc, hs, done, to_hit;
    #1;
    exp_rdy = !m_busy && !m_rel && (!m_ov || out_ack);
    chk("in_ready", in_ready, exp_rdy);
    acc  = in_valid && exp_rdy;
    hs   = m_ov && out_ack;
    done = m_busy && core_ready;
    to_hit = 1'b0;
`ifdef REQACK_TIMEOUT_EN
    to_hit = m_busy && !core_ready && (m_to == TO - 1);
`endif
    if (hs) begin
      m_ov = 0;
      dl_q.push_back(out_data);
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("deliver", out_data, sb_q.pop_front());
    end
    if (done) begin
      m_busy = 0; m_rel = 1; m_ov = 1;
      m_od = core_result; m_cnt = m_cnt + 1;
    end else if (to_hit) begin
      m_busy = 0; m_rel = 1; m_err = 1;
      void'(sb_q.pop_back());
    end else if (m_busy) begin
      m_to++;
    end else if (m_rel && !core_ready) begin
      m_rel = 0;
    end else if (acc) begin
      m_busy = 1; m_to = 0; m_cd = in_data;
      sb_q.push_back(xform(in_data));
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("core_enable", core_enable, m_busy);
    chk("core_data", core_data, m_cd);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, m_od);
    chk("pix_count", pix_count, m_cnt);
    chk("err_timeout", err_timeout, m_err);
    if (auto_core) begin
      if (core_enable && !core_ready) begin
        if (lat == 0) begin
          core_ready  = 1'b1;
          core_result = xform(core_data);
        end else lat--;
      end else if (!core_enable && core_ready) begin
        if (hold == 0) begin
          core_ready  = 1'b0;
          core_result = '0;
          lat  = $urandom_range(lat_hi, lat_lo);
          hold = $urandom_range(hold_hi, hold_lo);
        end else hold--;
      end
    end
  endtask

  task automatic feed(string tag, int max_t);
    int t = 0;
    while (t < max_t &&
           (feed_q.size() > 0 || m_busy || m_rel)) begin
      in_valid = (feed_q.size() > 0);
      if (in_valid) in_data = feed_q[0];
      tick();
      t++;
      if (last_acc) void'(feed_q.pop_front());
    end
    in_valid = 1'b0;
    chk({tag, "_done"},
        (feed_q.size() == 0 && !m_busy && !m_rel), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0]   base;
    logic [DW-1:0] saved;
    int            n;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("por_en", core_enable, 0);
    chk("por_ov", out_valid, 0);
    chk("por_cnt", pix_count, 0);
    chk("por_err", err_timeout, 0);
    chk("por_rdy", in_ready, 1);

    // gray-style pixel, core answers after a short wait
    mode = 1; lat = 1; hold = 0; out_ack = 0;
    feed_q = '{24'h000080};
    feed("t2", 12);
    chk("t2_ov", out_valid, 1);
    chk("t2_out", out_data, 24'h0000C0);
    chk("t2_cnt", pix_count, 1);
    out_ack = 1;
    tick();
    dl_q.delete();

    // back-to-back RGB, downstream always ready
    mode = 0; lat = 0; hold = 0;
    feed_q = '{24'h102030, 24'h405060};
    feed("t3", 20);
    tick();
    chk("t3_n", dl_q.size(), 2);
    if (dl_q.size() == 2) begin
      chk("t3_o0", dl_q[0], 24'h112131);
      chk("t3_o1", dl_q[1], 24'h415161);
    end
    chk("t3_cnt", pix_count, 3);

    // downstream stall then ack with a waiting pixel
    out_ack = 0;
    feed_q = '{24'h0A0B0C};
    feed("t4", 12);
    saved = out_data;
    in_valid = 1; in_data = 24'h111111;
    repeat (10) tick();
    chk("t4_hold", out_data, 24'h0B0C0D);
    chk("t4_same", out_data, saved);
    out_ack = 1;
    tick();
    chk("t4_nobubble", last_acc, 1);
    in_valid = 0;
    feed("t4b", 12);
    tick();

    // core keeps ready high after release
    base = pix_count;
    lat = 0; hold = 4; hold_lo = 4; hold_hi = 4;
    feed_q = '{24'h203040, 24'h506070};
    feed("t5", 40);
    chk("t5_cnt", pix_count, base + 2);
    hold_lo = 0; hold_hi = 0; hold = 0;

    // reset in the middle of a request
    auto_core = 0; core_ready = 0; out_ack = 0;
    in_valid = 1; in_data = 24'h0F0F0F;
    tick();
    in_valid = 0;
    tick();
    chk("rst_pre_en", core_enable, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_en", core_enable, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_cnt", pix_count, 0);
    chk("rst_err", err_timeout, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    auto_core = 1; lat = 0; hold = 0;

    // random traffic
    lat_lo = 0; lat_hi = 3; hold_lo = 0; hold_hi = 3;
    base = m_cnt;
    repeat (600) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_data  = DW'($urandom);
      out_ack  = ($urandom_range(2, 0) != 0);
      tick();
    end
    in_valid = 0; out_ack = 1;
    repeat (15) tick();
    chk("rnd_drain", sb_q.size(), 0);
    chk("rnd_progress", (m_cnt - base) > 50, 1);

`ifdef REQACK_TIMEOUT_EN
    base = pix_count;
    auto_core = 0; core_ready = 0; out_ack = 1;
    in_valid = 1; in_data = 24'h777777;
    tick();
    in_valid = 0;
    n = 0;
    repeat (12) begin
      if (core_enable) n++;
      tick();
    end
    chk("to_en_cycles", n, TO);
    chk("to_err", err_timeout, 1);
    chk("to_ov", out_valid, 0);
    chk("to_cnt", pix_count, base);
    auto_core = 1; lat = 0; hold = 0;
    lat_lo = 0; lat_hi = 0; hold_lo = 0; hold_hi = 0;
    feed_q = '{24'h010203};
    feed("to_next", 12);
    chk("to_next_cnt", pix_count, base + 1);
    chk("to_sticky", err_timeout, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
